// File: rtl/scfifo_ctrl_pkg.sv
// rtl/scfifo_ctrl_pkg.sv - shared types and helpers for the scfifo round-robin controller
package scfifo_ctrl_pkg;

    localparam int NUM_REQ_DEFAULT    = 4;
    localparam int PTR_W              = $clog2(NUM_REQ_DEFAULT);
    localparam int LPM_WIDTHU_DEFAULT = 8;

    typedef logic [LPM_WIDTHU_DEFAULT-1:0] count_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index reached by stepping idx positions past ptr on an n-entry ring.
    function automatic int rr_next(input int ptr, input int idx, input int n);
        return (ptr + idx) % n;
    endfunction

endpackage

// File: rtl/scfifo_rr_ctrl_rr_arbiter.sv
// rtl/scfifo_rr_ctrl_rr_arbiter.sv - combinational round-robin picker starting at ptr
module rr_arbiter
    import scfifo_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ptr_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic         enable_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = W'(rr_next(int'(ptr_i), k, N));
            if (enable_i && !any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/scfifo_rr_ctrl.sv
// rtl/scfifo_rr_ctrl.sv - round-robin write arbitration, occupancy and read sequencing for one scfifo
module scfifo_rr_ctrl
    import scfifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int DATA_W       = 1,
    parameter int lpm_numwords = 128,
    parameter int lpm_widthu   = LPM_WIDTHU_DEFAULT,
    parameter int AF_MARGIN    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_wrreq,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      fifo_sclr,
    output logic                      fifo_rdreq,
    input  logic [DATA_W-1:0]         fifo_q,
    input  logic                      fifo_empty,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [lpm_widthu-1:0]     count,
    output logic                      almost_full,
    output logic                      err
);

    typedef logic [lpm_widthu-1:0] cnt_t;

    localparam int   RR_W  = ptr_width(NUM_REQ);
    localparam cnt_t NUMW  = cnt_t'(lpm_numwords);
    localparam cnt_t AF_TH = cnt_t'(lpm_numwords - AF_MARGIN);

    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    cnt_t              count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              almost_full_q, almost_full_d;
    logic              err_q, err_d;

    logic              wr_ok;
    logic              arb_any;
    logic [RR_W-1:0]   arb_idx;

    // Only the registered count gates writes; a same-cycle read never frees a slot.
    assign wr_ok = (count_q < NUMW);

    rr_arbiter #(
        .N (NUM_REQ),
        .W (RR_W)
    ) u_arb (
        .req_i    (req),
        .enable_i (wr_ok & ~reset),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    assign fifo_wrreq = arb_any;
    assign fifo_sclr  = reset;
    assign fifo_rdreq = ~reset & out_ready & ~fifo_empty & (count_q != '0);

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fifo_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb_any) begin
            rr_ptr_d = RR_W'(rr_next(int'(arb_idx), 1, NUM_REQ));
        end
        count_d = count_q;
        case ({fifo_wrreq, fifo_rdreq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        out_valid_d   = fifo_rdreq;
        out_data_d    = fifo_rdreq ? fifo_q : out_data_q;
        almost_full_d = (count_d >= AF_TH);
        // A non-empty FIFO with zero tracked words, or a write into a full one, means we lost sync.
        err_d = err_q | ((count_q == '0) & ~fifo_empty) | ((count_q == NUMW) & fifo_wrreq);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            almost_full_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            almost_full_q <= almost_full_d;
            err_q         <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign err         = err_q;

endmodule

// File: tb/tb_scfifo_rr_ctrl.sv
// tb/tb_scfifo_rr_ctrl.sv - randomized self-checking bench with a queue-based scfifo and controller model
module tb_scfifo_rr_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NW = 8;
    localparam int WU = 4;
    localparam int AF = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic            fifo_wrreq;
    logic [DW-1:0]   fifo_data;
    logic            fifo_sclr;
    logic            fifo_rdreq;
    logic [DW-1:0]   fifo_q;
    logic            fifo_empty;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [WU-1:0]   count;
    logic            almost_full;
    logic            err;

    always #5 clock = ~clock;

    scfifo_rr_ctrl #(
        .NUM_REQ      (N),
        .DATA_W       (DW),
        .lpm_numwords (NW),
        .lpm_widthu   (WU),
        .AF_MARGIN    (AF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .fifo_sclr   (fifo_sclr),
        .fifo_rdreq  (fifo_rdreq),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .err         (err)
    );

    // Model: the FIFO contents double as the expected occupancy and read order.
    logic [DW-1:0] mq[$];
    int            ptr_m = 0;
    bit            ov_m = 0, af_m = 0, err_m = 0;
    logic [DW-1:0] od_m = '0;
    bit            chk_en = 0;
    bit            force_empty = 0, force_notempty = 0;

    bit            e_reset = 1, e_wr = 0, e_rd = 0, e_empty = 1;
    int            e_idx = 0;
    logic [DW-1:0] e_word = '0;

    int errs = 0;
    int checks = 0;
    logic [DW-1:0] w0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [N-1:0] g;
        int idx;
        int p;
        g   = '0;
        idx = -1;
        if (!reset && mq.size() < NW) begin
            for (int k = 0; k < N; k++) begin
                p = (ptr_m + k) % N;
                if (idx < 0 && req[p]) idx = p;
            end
        end
        if (idx >= 0) g[idx] = 1'b1;
        e_reset = reset;
        e_wr    = (idx >= 0);
        e_idx   = idx;
        e_word  = e_wr ? req_data[idx*DW +: DW] : '0;
        e_empty = fifo_empty;
        e_rd    = !reset && out_ready && !fifo_empty && mq.size() != 0;
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(g));
            chk("fifo_wrreq", 32'(fifo_wrreq), 32'(e_wr));
            if (e_wr) chk("fifo_data", 32'(fifo_data), 32'(e_word));
            chk("fifo_sclr", 32'(fifo_sclr), 32'(reset));
            chk("fifo_rdreq", 32'(fifo_rdreq), 32'(e_rd));
            chk("out_valid", 32'(out_valid), 32'(ov_m));
            chk("out_data", 32'(out_data), 32'(od_m));
            chk("count", 32'(count), 32'(mq.size()));
            chk("almost_full", 32'(almost_full), 32'(af_m));
            chk("err", 32'(err), 32'(err_m));
        end
    end

    task automatic model_update();
        if (e_reset) begin
            mq.delete();
            ptr_m  = 0;
            ov_m   = 0;
            od_m   = '0;
            af_m   = 0;
            err_m  = 0;
            chk_en = 1;
        end else begin
            if (mq.size() == 0 && !e_empty) err_m = 1;
            ov_m = e_rd;
            if (e_rd) od_m = mq.pop_front();
            if (e_wr) begin
                mq.push_back(e_word);
                ptr_m = (e_idx + 1) % N;
            end
            af_m = (mq.size() >= NW - AF);
        end
    endtask

    task automatic settle();
        fifo_empty = force_notempty ? 1'b0 : (mq.size() == 0 || force_empty);
        fifo_q     = (mq.size() > 0) ? mq[0] : '0;
        #2;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        model_update();
    endtask

    task automatic drain();
        req       = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3 * NW && mq.size() != 0; k++) begin
            settle();
            cycle();
        end
    endtask

    initial begin
        logic [N-1:0] exp3[3];
        reset = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
        settle(); cycle();
        settle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sclr", 32'(fifo_sclr), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        cycle();

        // Fill with all producers requesting.
        reset = 1'b0; req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            req_data = $urandom;
            if (i == 0) w0 = req_data[DW-1:0];
            settle();
            chk("t1_grant", 32'(grant), 32'(1 << (i % 4)));
            cycle();
        end
        settle();
        chk("t1_full_grant", 32'(grant), 32'h0);
        chk("t1_count", 32'(count), 32'd8);
        chk("t1_af", 32'(almost_full), 32'h1);
        chk("t1_err", 32'(err), 32'h0);
        cycle();

        out_ready = 1'b1;
        settle();
        chk("t2_rdreq", 32'(fifo_rdreq), 32'h1);
        cycle();
        out_ready = 1'b0;
        settle();
        chk("t2_count", 32'(count), 32'd7);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_data", 32'(out_data), 32'(w0));
        chk("t2_grant", 32'(grant), 32'h1);
        cycle();

        drain();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_lone", 32'(grant), 32'h4);
            cycle();
        end
        exp3[0] = 4'b1000; exp3[1] = 4'b0001; exp3[2] = 4'b1000;
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_pair", 32'(grant), 32'(exp3[i]));
            cycle();
        end

        drain();
        out_ready = 1'b0; req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            req_data = $urandom;
            settle(); cycle();
        end
        req = 4'b0010; out_ready = 1'b1; req_data = $urandom;
        settle();
        chk("t4_count", 32'(count), 32'd3);
        chk("t4_wr", 32'(fifo_wrreq), 32'h1);
        chk("t4_rd", 32'(fifo_rdreq), 32'h1);
        cycle();
        req = '0; out_ready = 1'b0;
        settle();
        chk("t4_count_hold", 32'(count), 32'd3);
        chk("t4_valid", 32'(out_valid), 32'h1);
        cycle();

        drain();
        req = 4'b0001; force_empty = 1'b1; req_data = $urandom;
        settle(); cycle();
        req = '0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t5_lag_rd", 32'(fifo_rdreq), 32'h0);
            cycle();
        end
        force_empty = 1'b0;
        settle();
        chk("t5_rd", 32'(fifo_rdreq), 32'h1);
        cycle();
        settle();
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_count", 32'(count), 32'h0);
        chk("t5_err", 32'(err), 32'h0);
        cycle();

        out_ready = 1'b0; req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_data = $urandom;
            settle(); cycle();
        end
        out_ready = 1'b1;
        settle(); cycle();
        reset = 1'b1; req = 4'b1111;
        settle();
        chk("t6_count", 32'(count), 32'd5);
        chk("t6_valid", 32'(out_valid), 32'h1);
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_sclr", 32'(fifo_sclr), 32'h1);
        chk("t6_rd", 32'(fifo_rdreq), 32'h0);
        cycle();
        reset = 1'b0; req = '0; out_ready = 1'b0; force_notempty = 1'b1;
        settle();
        chk("t6_count0", 32'(count), 32'h0);
        chk("t6_valid0", 32'(out_valid), 32'h0);
        cycle();
        force_notempty = 1'b0;
        settle();
        chk("t6_err", 32'(err), 32'h1);
        cycle();
        settle();
        chk("t6_err_sticky", 32'(err), 32'h1);
        cycle();
        reset = 1'b1;
        settle(); cycle();
        reset = 1'b0;
        settle();
        chk("t6_err_clr", 32'(err), 32'h0);
        cycle();

        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            req         = N'($urandom);
            req_data    = $urandom;
            out_ready   = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 7) == 0);
            settle(); cycle();
        end
        reset = 1'b0; force_empty = 1'b0;
        settle(); cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
